mult_div_unit: RTL

//   Iterative HI/LO multiply/divide unit beside the EX stage of the pipelined MIPS CPU.

---
 rtl/mult_div_unit.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit
// ----------------------------------------------------------------------------
// Iterative HI/LO multiply/divide unit that sits beside the EX stage of the
// pipelined MIPS core. It executes MULT/MULTU/DIV/DIVU and services MTHI/MTLO.
// HI/LO feed the MFHI/MFLO forwarding path. busy lets the hazard unit stall
// any HI/LO-touching instruction until the result lands.
//
// Operation sequence: IDLE -> RUN (WIDTH iterations) -> FIX -> IDLE.
//   - Multiply uses shift-add on a 2*WIDTH accumulator.
//   - Divide uses restoring shift-subtract, one quotient bit per cycle.
//   - Signed ops work on magnitudes; FIX re-applies the signs.
//   - done pulses in the cycle where the new HI/LO first become visible.
//
// Optional feature macro: MULT_DIV_FAST_MUL_EN
//   Defined  : MULT/MULTU complete in a single cycle via an array multiply.
//              busy stays low. DIV/DIVU are unchanged.
//   Undefined: every op uses the iterative path, with (WIDTH+2)-cycle latency.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous active-high reset
//   start    in   1      launch op with a/b (sampled only in IDLE)
//   op       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a        in   WIDTH  rs operand (multiplicand / dividend)
//   b        in   WIDTH  rt operand (multiplier / divisor)
//   hiWrite  in   1      MTHI strobe
//   loWrite  in   1      MTLO strobe
//   wdata    in   WIDTH  MTHI/MTLO data
//   busy     out  1      operation in flight
//   done     out  1      one-cycle completion pulse
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Two's-complement negate of a WIDTH-bit value when neg is set.
  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x,
                                                  input logic             neg);
    cond_neg_w = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Two's-complement negate of a 2*WIDTH-bit value when neg is set.
  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                     input logic               neg);
    cond_neg_2w = neg ? (~x + {{(2*WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  // Working register: multiply = {partial product, multiplier};
  // divide = {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q;
  // Multiply: |multiplicand|; divide: |divisor|.
  logic [WIDTH-1:0]     opnd_q;
  logic                 sign_a_q;
  logic                 sign_b_q;
  logic                 is_div_q;
  logic                 div_zero_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;

  logic                 launch_s;
  logic                 launch_iter_s;
  logic                 fast_mul_s;
  logic [2*WIDTH-1:0]   fast_prod_s;
  logic                 sgn_a_s;
  logic                 sgn_b_s;
  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH+1:0]     div_diff_s;
  logic [2*WIDTH-1:0]   acc_step_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quot_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     fix_hi_s;
  logic [WIDTH-1:0]     fix_lo_s;

  assign launch_s = (state_q == S_IDLE) && start;

`ifdef MULT_DIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;

  // Single-cycle product. Sign-extending both operands to 2*WIDTH makes the
  // truncated unsigned product equal the signed product for MULT.
  always_comb begin
    ext_a_s     = {{WIDTH{op[0] & a[WIDTH-1]}}, a};
    ext_b_s     = {{WIDTH{op[0] & b[WIDTH-1]}}, b};
    fast_prod_s = ext_a_s * ext_b_s;
  end

  assign fast_mul_s = launch_s & ~op[1];
`else
  assign fast_mul_s  = 1'b0;
  assign fast_prod_s = {(2*WIDTH){1'b0}};
`endif

  assign launch_iter_s = launch_s & ~fast_mul_s;

  // Launch-time operand conditioning: magnitudes are taken only for signed ops.
  always_comb begin
    sgn_a_s = op[0] & a[WIDTH-1];
    sgn_b_s = op[0] & b[WIDTH-1];
    mag_a_s = cond_neg_w(a, sgn_a_s);
    mag_b_s = cond_neg_w(b, sgn_b_s);
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    // Partial remainder shifted left, taking in the next dividend bit.
    div_shift_s = acc_q[2*WIDTH-1:WIDTH-1];
    // One extra guard bit so that the borrow is unambiguous.
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_q};
    if (is_div_q) begin
      if (div_diff_s[WIDTH+1]) begin
        acc_step_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_step_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and result selection applied on leaving FIX.
  always_comb begin
    prod_s = cond_neg_2w(acc_q, sign_a_q ^ sign_b_q);
    rem_s  = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], sign_a_q);
    // With a zero divisor, every subtract succeeds. This leaves rem = |a|, so
    // the remainder sign fix alone restores the raw dividend. Only the
    // quotient needs to be forced.
    if (div_zero_q) begin
      quot_s = {WIDTH{1'b1}};
    end else begin
      quot_s = cond_neg_w(acc_q[WIDTH-1:0], sign_a_q ^ sign_b_q);
    end
    if (is_div_q) begin
      fix_hi_s = rem_s;
      fix_lo_s = quot_s;
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (launch_iter_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // Datapath, counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= {CNT_W{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      opnd_q     <= {WIDTH{1'b0}};
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIX) | fast_mul_s;
      case (state_q)
        S_IDLE: begin
          if (launch_iter_s) begin
            cnt_q      <= {CNT_W{1'b0}};
            sign_a_q   <= sgn_a_s;
            sign_b_q   <= sgn_b_s;
            is_div_q   <= op[1];
            div_zero_q <= op[1] & (b == {WIDTH{1'b0}});
            if (op[1]) begin
              acc_q  <= {{WIDTH{1'b0}}, mag_a_s};
              opnd_q <= mag_b_s;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, mag_b_s};
              opnd_q <= mag_a_s;
            end
          end else if (fast_mul_s) begin
            hi_q <= fast_prod_s[2*WIDTH-1:WIDTH];
            lo_q <= fast_prod_s[WIDTH-1:0];
          end else begin
            // MTHI/MTLO are accepted only here. A simultaneous start has
            // already taken the branch above, so the write is dropped.
            if (hiWrite) begin
              hi_q <= wdata;
            end else begin
              hi_q <= hi_q;
            end
            if (loWrite) begin
              lo_q <= wdata;
            end else begin
              lo_q <= lo_q;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_step_s;
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        S_FIX: begin
          hi_q <= fix_hi_s;
          lo_q <= fix_lo_s;
        end
        default: begin
          cnt_q <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
